alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 118 +++++++++++
 tb/tb_alu_writeback.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU write-back stage: ARM condition evaluation, CPSR NZCV update and a single-entry register-file write buffer.
// Optional annulled-instruction counter enabled by defining ALU_WRITEBACK_FAIL_COUNT_EN.
module alu_writeback #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            cond,
  input  logic [3:0]            rd,
  input  logic                  write_rd,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  flag_update,
  input  logic                  n_in,
  input  logic                  z_in,
  input  logic                  c_in,
  input  logic                  v_in,
  output logic [3:0]            cpsr_nzcv,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [3:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [15:0]           cond_fail_count
);

  // flags are ordered {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic pass;
    case (c)
      4'h0:    pass = f[2];
      4'h1:    pass = !f[2];
      4'h2:    pass = f[1];
      4'h3:    pass = !f[1];
      4'h4:    pass = f[3];
      4'h5:    pass = !f[3];
      4'h6:    pass = f[0];
      4'h7:    pass = !f[0];
      4'h8:    pass = f[1] && !f[2];
      4'h9:    pass = !f[1] || f[2];
      4'hA:    pass = (f[3] == f[0]);
      4'hB:    pass = (f[3] != f[0]);
      4'hC:    pass = !f[2] && (f[3] == f[0]);
      4'hD:    pass = f[2] || (f[3] != f[0]);
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  logic [3:0]            cpsr_r;
  logic                  wb_valid_r;
  logic [3:0]            wb_rd_r;
  logic [DATA_WIDTH-1:0] wb_data_r;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  pass_s;
  logic                  load_s;
  logic                  flag_wr_s;
  logic                  annul_s;

  // Handshake and condition decode for the instruction presented this cycle.
  always_comb begin
    in_ready_s = !wb_valid_r || wb_ready;
    accept_s   = in_valid && in_ready_s;
    pass_s     = cond_pass(cond, cpsr_r);
    load_s     = accept_s && pass_s && write_rd;
    flag_wr_s  = accept_s && pass_s && flag_update;
    annul_s    = accept_s && !pass_s;
  end

  // CPSR flags and write-back buffer; a drain and a load on the same edge keep the buffer full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpsr_r     <= 4'b0000;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 4'd0;
      wb_data_r  <= '0;
    end else begin
      if (flag_wr_s) begin
        cpsr_r <= {n_in, z_in, c_in, v_in};
      end
      if (load_s) begin
        wb_valid_r <= 1'b1;
        wb_rd_r    <= rd;
        wb_data_r  <= result;
      end else if (wb_ready) begin
        wb_valid_r <= 1'b0;
      end
    end
  end

`ifdef ALU_WRITEBACK_FAIL_COUNT_EN
  logic [15:0] fail_cnt_r;

  // Saturating count of annulled instructions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_cnt_r <= 16'd0;
    end else if (annul_s && (fail_cnt_r != 16'hFFFF)) begin
      fail_cnt_r <= fail_cnt_r + 16'd1;
    end
  end

  assign cond_fail_count = fail_cnt_r;
`else
  logic unused_annul_s;
  assign unused_annul_s  = annul_s;
  assign cond_fail_count = 16'd0;
`endif

  assign in_ready  = in_ready_s;
  assign cpsr_nzcv = cpsr_r;
  assign wb_valid  = wb_valid_r;
  assign wb_rd     = wb_rd_r;
  assign wb_data   = wb_data_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized self-checking bench for alu_writeback with a behavioural reference model.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [3:0]  rd;
  logic        write_rd;
  logic [31:0] result;
  logic        flag_update;
  logic        n_in, z_in, c_in, v_in;
  logic [3:0]  cpsr_nzcv;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] cond_fail_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0]  m_nzcv;
  logic        m_wbv;
  logic [3:0]  m_rd;
  logic [31:0] m_data;
  int          m_fails;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .rd(rd), .write_rd(write_rd), .result(result),
    .flag_update(flag_update), .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .cpsr_nzcv(cpsr_nzcv), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .cond_fail_count(cond_fail_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ARM condition: pairs of codes share a base test, odd code inverts it; 14 always, 15 never
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef ALU_WRITEBACK_FAIL_COUNT_EN
    return (m_fails > 65535) ? 16'hFFFF : 16'(m_fails);
`else
    return 16'd0;
`endif
  endfunction

  task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] r, input logic w,
                       input logic [31:0] res, input logic fu, input logic [3:0] f, input logic wr);
    in_valid = v; cond = c; rd = r; write_rd = w; result = res;
    flag_update = fu; {n_in, z_in, c_in, v_in} = f; wb_ready = wr;
  endtask

  task automatic check_outputs();
    check_eq("cpsr_nzcv", 64'(cpsr_nzcv), 64'(m_nzcv));
    check_eq("wb_valid", 64'(wb_valid), 64'(m_wbv));
    if (m_wbv || !rst_n) begin
      check_eq("wb_rd", 64'(wb_rd), 64'(m_rd));
      check_eq("wb_data", 64'(wb_data), 64'(m_data));
    end
    check_eq("cond_fail_count", 64'(cond_fail_count), 64'(exp_count()));
  endtask

  // one clock: check ready, predict the edge, then compare after it
  task automatic tick();
    bit exp_ready, acc, pass;
    logic [3:0] n_nzcv; logic n_wbv; logic [3:0] n_rd; logic [31:0] n_data; int n_fails;
    #1;
    exp_ready = !m_wbv || wb_ready;
    check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
    acc = in_valid && exp_ready;
    pass = ref_cond(cond, m_nzcv);
    n_nzcv = m_nzcv; n_wbv = m_wbv; n_rd = m_rd; n_data = m_data; n_fails = m_fails;
    if (m_wbv && wb_ready) n_wbv = 1'b0;
    if (acc && pass && flag_update) n_nzcv = {n_in, z_in, c_in, v_in};
    if (acc && pass && write_rd) begin n_wbv = 1'b1; n_rd = rd; n_data = result; end
    if (acc && !pass) n_fails = m_fails + 1;
    if (!rst_n) begin n_nzcv = 4'd0; n_wbv = 1'b0; n_rd = 4'd0; n_data = 32'd0; n_fails = 0; end
    @(posedge clk);
    m_nzcv = n_nzcv; m_wbv = n_wbv; m_rd = n_rd; m_data = n_data; m_fails = n_fails;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'hE, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
    m_nzcv = 4'd0; m_wbv = 1'b0; m_rd = 4'd0; m_data = 32'd0; m_fails = 0;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    #1 check_eq("ready_after_reset", 64'(in_ready), 64'd1);
    @(negedge clk);

    // ADDS result 0, flags 0100, AL, rd 3
    drive(1'b1, 4'hE, 4'd3, 1'b1, 32'd0, 1'b1, 4'b0100, 1'b1);
    tick();
    check_eq("adds_nzcv", 64'(cpsr_nzcv), 64'h4);
    check_eq("adds_wb_rd", 64'(wb_rd), 64'd3);

    // CMP then ADDEQ back-to-back
    drive(1'b1, 4'hE, 4'd7, 1'b0, 32'd99, 1'b1, 4'b0100, 1'b1);
    tick();
    check_eq("cmp_no_write", 64'(wb_valid), 64'd0);
    drive(1'b1, 4'h0, 4'd1, 1'b1, 32'd5, 1'b0, 4'b0000, 1'b1);
    tick();
    check_eq("addeq_data", 64'(wb_data), 64'd5);

    // ADDNE with Z=1 is annulled
    drive(1'b1, 4'h1, 4'd2, 1'b1, 32'd9, 1'b1, 4'b1010, 1'b1);
    tick();
    check_eq("addne_annul_valid", 64'(wb_valid), 64'd0);
    check_eq("addne_flags_kept", 64'(cpsr_nzcv), 64'h4);

    // backpressure: hold, then drain and load on the same edge
    drive(1'b1, 4'hE, 4'd4, 1'b1, 32'h11, 1'b0, 4'd0, 1'b1);
    tick();
    drive(1'b1, 4'hE, 4'd5, 1'b1, 32'h22, 1'b0, 4'd0, 1'b0);
    tick();
    tick();
    check_eq("bp_hold_data", 64'(wb_data), 64'h11);
    wb_ready = 1'b1;
    tick();
    check_eq("bp_drain_load_data", 64'(wb_data), 64'h22);
    check_eq("bp_drain_load_valid", 64'(wb_valid), 64'd1);

    // reset mid-operation with an accept in flight
    drive(1'b1, 4'hE, 4'd6, 1'b1, 32'h33, 1'b1, 4'b1111, 1'b1);
    rst_n = 1'b0;
    tick();
    check_eq("rst_mid_valid", 64'(wb_valid), 64'd0);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), $urandom,
            1'($urandom), 4'($urandom), ($urandom_range(3) != 0));
      rst_n = ($urandom_range(199) != 0);
      tick();
    end
    rst_n = 1'b1;

    // long run of annulled NV instructions to reach saturation
    drive(1'b1, 4'hF, 4'd8, 1'b1, 32'h44, 1'b1, 4'b1111, 1'b1);
    tick();
    for (int i = 0; i < 65539; i++) @(posedge clk);
    m_fails = m_fails + 65539;
    @(negedge clk);
    check_outputs();
`ifdef ALU_WRITEBACK_FAIL_COUNT_EN
    check_eq("nv_saturate", 64'(cond_fail_count), 64'hFFFF);
`else
    check_eq("nv_count_tied", 64'(cond_fail_count), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
